// File: rtl/computie_uart_pkg.sv
// Shared types and helpers for the snooper's UART path.
// The optional parity bit is enabled in the top level by defining SNOOP_UART_PARITY_EN.
package computie_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/computie_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through read data.
// The level counter is kept separately from the pointers so full and empty are never ambiguous.
module computie_byte_fifo
    import computie_uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/computie_snoop_uart_tx.sv
// Serialises the snooper's ASCII dump stream as 8N1 UART through a byte FIFO.
// Define SNOOP_UART_PARITY_EN to insert an even-parity bit after the data bits.
module computie_snoop_uart_tx
    import computie_uart_pkg::*;
#(
    parameter int CLOCK_HZ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          comm_clock,
    input  logic                          comm_reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
    localparam int              CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST     = CW'(CLKS_PER_BIT - 1);

    uart_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          pop;
    logic          bit_end;
    logic [7:0]    fifo_rdata;
    logic          fifo_full, fifo_empty;
`ifdef SNOOP_UART_PARITY_EN
    logic          par, par_n;
`endif

    computie_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (comm_clock),
        .rst_n (comm_reset),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || (fifo_level != '0);
    assign bit_end  = (cnt == CNT_LAST);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        tx_n    = tx;
        pop     = 1'b0;
`ifdef SNOOP_UART_PARITY_EN
        par_n   = par;
`endif
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                tx_n  = TX_IDLE_LEVEL;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_rdata;
`ifdef SNOOP_UART_PARITY_EN
                    par_n   = ^fifo_rdata;
`endif
                    tx_n    = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: if (bit_end) begin
                cnt_n   = '0;
                tx_n    = shreg[0];
                shreg_n = {1'b0, shreg[7:1]};
                idx_n   = '0;
                state_n = ST_DATA;
            end
            ST_DATA: if (bit_end) begin
                cnt_n = '0;
                if (idx == 3'd7) begin
`ifdef SNOOP_UART_PARITY_EN
                    tx_n    = par;
                    state_n = ST_PARITY;
`else
                    tx_n    = TX_IDLE_LEVEL;
                    state_n = ST_STOP;
`endif
                end else begin
                    tx_n    = shreg[0];
                    shreg_n = {1'b0, shreg[7:1]};
                    idx_n   = idx + 1'b1;
                end
            end
            ST_PARITY: if (bit_end) begin
                cnt_n   = '0;
                tx_n    = TX_IDLE_LEVEL;
                state_n = ST_STOP;
            end
            ST_STOP: if (bit_end) begin
                cnt_n = '0;
                // Chain straight into the next start bit so queued bytes leave with no idle gap.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_rdata;
`ifdef SNOOP_UART_PARITY_EN
                    par_n   = ^fifo_rdata;
`endif
                    tx_n    = 1'b0;
                    state_n = ST_START;
                end else begin
                    tx_n    = TX_IDLE_LEVEL;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                tx_n    = TX_IDLE_LEVEL;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge comm_clock or negedge comm_reset) begin
        if (!comm_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= TX_IDLE_LEVEL;
`ifdef SNOOP_UART_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            tx    <= tx_n;
`ifdef SNOOP_UART_PARITY_EN
            par   <= par_n;
`endif
        end
    end

endmodule
